// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM pipeline stage.
//   wb_sel_e    - write-back source select (ALU, MEM, PC+2, IMM)
//   mem_state_e - MEM-stage sequencer states
//   TIMEOUT_W   - width of the optional access watchdog counter
package mem_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC2 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam int TIMEOUT_W = 8;

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory request/grant/valid channel of the MEM stage.
//
// Handshake: dmem_req is held high with dmem_we/dmem_addr/dmem_wdata stable
// until the memory answers with dmem_gnt in the same cycle; the request is
// accepted on that clock edge. For a load, the data comes back later as a
// one-cycle dmem_rvalid pulse carrying dmem_rdata. rvalid outside the wait
// phase of a load is ignored by the stage.
//
// fsm_state mirrors the stage sequencer state for observation.
//   master: the MEM stage (drives request + fsm_state, receives gnt/response)
//   slave : the data memory
interface mem_access_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [15:0] dmem_rdata;
  logic [1:0]  fsm_state;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, fsm_state,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, fsm_state,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/wb_mux.sv
// wb_mux: combinational 4:1 write-back value select.
//   sel  - write-back source (mem_pkg::wb_sel_e)
//   alu  - ALU result
//   mem  - captured load data
//   pc2  - PC+2 (link value)
//   imm  - effective immediate
//   data - selected write-back value
module wb_mux
  import mem_pkg::*;
(
  input  wb_sel_e     sel,
  input  logic [15:0] alu,
  input  logic [15:0] mem,
  input  logic [15:0] pc2,
  input  logic [15:0] imm,
  output logic [15:0] data
);

  always_comb begin
    data = alu;
    unique case (sel)
      WB_ALU: data = alu;
      WB_MEM: data = mem;
      WB_PC2: data = pc2;
      WB_IMM: data = imm;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage. Performs loads/stores over the
// request/grant/valid data-memory channel, selects the write-back value and
// registers it into the MEM/WB boundary. mem_stall freezes the PC and all
// upstream pipeline registers while a memory access is in flight.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Adds a watchdog that forces an access to complete after TIMEOUT_CYCLES
//   cycles in REQ/WAIT, writing back 16'hFFFF with rf_we_out=0 and raising
//   mem_err_out for that instruction. Without it the stage waits forever and
//   mem_err_out is tied low.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   alu_res_in                - ALU result / memory address
//   store_data_in             - store data
//   pc2_in, imm_eff_in        - alternative write-back values
//   rf_we_in, rf_waddr_in     - register-file write control
//   wb_sel_in                 - write-back source (0 ALU,1 MEM,2 PC+2,3 IMM)
//   mem_rd_in, mem_wr_in      - load / store (both high = store)
//   dmem                      - data-memory channel (master side)
//   mem_stall                 - combinational upstream freeze
//   wb_data_out, rf_we_out, rf_waddr_out - MEM/WB register
//   mem_err_out               - registered timeout flag for this instruction
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         alu_res_in,
  input  logic [15:0]         store_data_in,
  input  logic [15:0]         pc2_in,
  input  logic [15:0]         imm_eff_in,
  input  logic                rf_we_in,
  input  logic [2:0]          rf_waddr_in,
  input  logic [1:0]          wb_sel_in,
  input  logic                mem_rd_in,
  input  logic                mem_wr_in,
  mem_access_stage_if.master  dmem,
  output logic                mem_stall,
  output logic [15:0]         wb_data_out,
  output logic                rf_we_out,
  output logic [2:0]          rf_waddr_out,
  output logic                mem_err_out
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [TIMEOUT_W-1:0] TMO_LIM = TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] load_q;
  logic [15:0] mux_data;
  logic [15:0] wb_data_nxt;
  logic        rf_we_nxt;
  logic        mem_op;
  logic        timeout_hit;
  logic        tmo_force;
  logic        timed_out_q;
  wb_sel_e     sel;

  assign mem_op = mem_rd_in | mem_wr_in;
  assign sel    = wb_sel_e'(wb_sel_in);

  // DONE is the only cycle of a memory op where MEM/WB may load.
  assign mem_stall = mem_op && (state != S_DONE);

  // Request channel is driven only in REQ so everything else reads as 0.
  assign dmem.dmem_req   = (state == S_REQ);
  assign dmem.dmem_we    = (state == S_REQ) & mem_wr_in;
  assign dmem.dmem_addr  = (state == S_REQ) ? alu_res_in    : 16'h0000;
  assign dmem.dmem_wdata = (state == S_REQ) ? store_data_in : 16'h0000;
  assign dmem.fsm_state  = state;

  always_comb begin
    state_nxt = state;
    tmo_force = 1'b0;
    case (state)
      S_IDLE: if (mem_op) state_nxt = S_REQ;
      S_REQ: begin
        if (dmem.dmem_gnt) begin
          state_nxt = mem_wr_in ? S_DONE : S_WAIT;
        end else if (timeout_hit) begin
          state_nxt = S_DONE;
          tmo_force = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem.dmem_rvalid) begin
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          state_nxt = S_DONE;
          tmo_force = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Response is only accepted while waiting for it; rvalid in any other
  // state (including the grant cycle) is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q <= 16'h0000;
    end else if ((state == S_WAIT) && dmem.dmem_rvalid) begin
      load_q <= dmem.dmem_rdata;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 err_q;

  // Compare against the value the counter would reach this cycle so that
  // exactly TIMEOUT_CYCLES cycles are spent in REQ/WAIT before DONE.
  assign timeout_hit = ((state == S_REQ) || (state == S_WAIT)) &&
                       ((tmo_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1}) == TMO_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if ((state == S_IDLE) && mem_op) begin
      tmo_cnt <= '0;
    end else if ((state == S_REQ) || (state == S_WAIT)) begin
      tmo_cnt <= tmo_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end
  end

  // High exactly during the DONE cycle that the watchdog forced.
  always_ff @(posedge clk) begin
    if (rst) begin
      timed_out_q <= 1'b0;
    end else begin
      timed_out_q <= tmo_force;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (!mem_stall) begin
      err_q <= timed_out_q;
    end
  end

  assign mem_err_out = err_q;
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign timed_out_q = 1'b0;
  assign mem_err_out = 1'b0;
  assign unused_cfg  = ^{TMO_LIM, tmo_force};
`endif

  wb_mux u_wb_mux (
    .sel  (sel),
    .alu  (alu_res_in),
    .mem  (load_q),
    .pc2  (pc2_in),
    .imm  (imm_eff_in),
    .data (mux_data)
  );

  // A timed-out access writes back a poison value and suppresses the write.
  assign wb_data_nxt = timed_out_q ? 16'hFFFF : mux_data;
  assign rf_we_nxt   = rf_we_in & ~timed_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_out  <= 16'h0000;
      rf_we_out    <= 1'b0;
      rf_waddr_out <= 3'd0;
    end else if (!mem_stall) begin
      wb_data_out  <= wb_data_nxt;
      rf_we_out    <= rf_we_nxt;
      rf_waddr_out <= rf_waddr_in;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed + randomized bench for mem_access_stage.
// The bench plays the data memory (grant/response timing chosen per op) and
// predicts, per instruction, the MEM/WB contents, stall length and request
// length from an op-level model (memory array + last loaded value).
// Define MEM_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=4).
module tb_mem_access_stage;
  import mem_pkg::*;

  localparam int TMO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT connections
  logic [15:0] alu_res, store_data, pc2, imm;
  logic        rf_we, mem_rd, mem_wr;
  logic [2:0]  waddr;
  logic [1:0]  wb_sel;
  logic        stall, rf_we_o, mem_err;
  logic [15:0] wb_data;
  logic [2:0]  waddr_o;

  mem_access_stage_if dmem_bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_res_in    (alu_res),
    .store_data_in (store_data),
    .pc2_in        (pc2),
    .imm_eff_in    (imm),
    .rf_we_in      (rf_we),
    .rf_waddr_in   (waddr),
    .wb_sel_in     (wb_sel),
    .mem_rd_in     (mem_rd),
    .mem_wr_in     (mem_wr),
    .dmem          (dmem_bus),
    .mem_stall     (stall),
    .wb_data_out   (wb_data),
    .rf_we_out     (rf_we_o),
    .rf_waddr_out  (waddr_o),
    .mem_err_out   (mem_err)
  );

  // scoreboard and reference model state
  logic [19:0] exp_q[$];
  logic [15:0] mem_arr [256];
  logic [15:0] ref_mem [256];
  logic [15:0] last_load;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_nop();
    alu_res = 16'h0; store_data = 16'h0; pc2 = 16'h0; imm = 16'h0;
    rf_we = 1'b0; waddr = 3'd0; wb_sel = 2'd0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic apply_reset();
    set_nop();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_load = 16'h0;
  endtask

  // Issues one instruction, answers its memory traffic, then checks MEM/WB.
  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] sel, input logic we, input logic [2:0] wa,
                        input int gd, input int rvd, input bit spur, input bit to);
    logic [15:0] p, i, val;
    logic        is_mem, is_load;
    logic [19:0] got, expv;
    int          exp_stall, exp_req, stall_n, req_n, since, cyc;
    bit          granted, done_ok;
    p = 16'($urandom);
    i = 16'($urandom);
    is_mem  = rd | wr;
    is_load = rd & ~wr;
    alu_res = a; store_data = d; pc2 = p; imm = i; wb_sel = sel;
    rf_we = we; waddr = wa; mem_rd = rd; mem_wr = wr;
    if (to) begin
      val = 16'hFFFF;
      exp_stall = 1 + TMO;
      exp_req = TMO;
    end else begin
      if (is_load) last_load = ref_mem[a[7:0]];
      case (sel)
        2'd0:    val = a;
        2'd1:    val = last_load;
        2'd2:    val = p;
        default: val = i;
      endcase
      if (wr) ref_mem[a[7:0]] = d;
      exp_stall = is_mem ? (2 + gd + (is_load ? rvd : 0)) : 0;
      exp_req   = is_mem ? (gd + 1) : 0;
    end
    exp_q.push_back({(to ? 1'b0 : we), wa, val});
    stall_n = 0; req_n = 0; since = 0; cyc = 0; granted = 0; done_ok = 1;
    while (1) begin
      @(negedge clk);
      if (!stall) break;
      stall_n++;
      if (dmem_bus.dmem_req) begin
        req_n++;
        check({tag, "_addr"},  {16'h0, dmem_bus.dmem_addr},  {16'h0, a});
        check({tag, "_wdata"}, {16'h0, dmem_bus.dmem_wdata}, {16'h0, d});
        check({tag, "_we"},    {31'h0, dmem_bus.dmem_we},    {31'h0, wr});
      end
      if (granted) since++;
      if (granted && since == rvd) begin
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = mem_arr[a[7:0]];
      end
      if (dmem_bus.dmem_req && req_n == gd + 1) begin
        dmem_bus.dmem_gnt = 1'b1;
        if (wr) mem_arr[a[7:0]] = d;
        if (spur && is_load) begin
          dmem_bus.dmem_rvalid = 1'b1;
          dmem_bus.dmem_rdata  = ~mem_arr[a[7:0]];
        end
        granted = 1;
      end
      @(posedge clk); #1;
      dmem_bus.dmem_gnt    = 1'b0;
      dmem_bus.dmem_rvalid = 1'b0;
      cyc++;
      if (cyc > 40) begin
        check({tag, "_stall_bound"}, stall_n, exp_stall);
        done_ok = 0;
        break;
      end
    end
    if (done_ok) begin
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      got  = {rf_we_o, waddr_o, wb_data};
      check({tag, "_wb"}, {12'h0, got}, {12'h0, expv});
      check({tag, "_stall"}, stall_n, exp_stall);
      if (is_mem) check({tag, "_req"}, req_n, exp_req);
      check({tag, "_err"}, {31'h0, mem_err}, {31'h0, to});
    end else begin
      void'(exp_q.pop_front());
      apply_reset();
    end
  endtask

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    dmem_bus.dmem_rdata  = 16'h0;
    for (int k = 0; k < 256; k++) begin
      mem_arr[k] = 16'($urandom);
      ref_mem[k] = mem_arr[k];
    end
    last_load = 16'h0;
    set_nop();

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", {30'h0, dmem_bus.fsm_state}, 32'd0);
    check("rst_req",   {31'h0, dmem_bus.dmem_req}, 32'd0);
    check("rst_wb",    {12'h0, rf_we_o, waddr_o, wb_data}, 32'd0);
    check("rst_err",   {31'h0, mem_err}, 32'd0);
    check("rst_stall", {31'h0, stall}, 32'd0);
    @(posedge clk); #1;

    // ALU op, single-cycle, no stall
    run_op("alu", 0, 0, 16'h1234, 16'h0, 2'd0, 1, 3'd3, 0, 1, 0, 0);

    // store with grant withheld 2 cycles
    run_op("store", 0, 1, 16'h0040, 16'hBEEF, 2'd0, 0, 3'd1, 2, 1, 0, 0);

    // spurious rvalid while idle must not reach load_q
    set_nop();
    dmem_bus.dmem_rvalid = 1'b1;
    dmem_bus.dmem_rdata  = 16'h1111;
    @(posedge clk); #1;
    dmem_bus.dmem_rvalid = 1'b0;
    run_op("spur_idle", 0, 0, 16'h0, 16'h0, 2'd1, 1, 3'd4, 0, 1, 0, 0);

    // load with rvalid 3 cycles after grant, then ALU op right behind it
    mem_arr[8'h10] = 16'hA5A5;
    ref_mem[8'h10] = 16'hA5A5;
    run_op("load", 1, 0, 16'h0010, 16'h0, 2'd1, 1, 3'd5, 0, 3, 1, 0);
    run_op("alu_after_load", 0, 0, 16'h0007, 16'h0, 2'd0, 1, 3'd6, 0, 1, 0, 0);

    // reset while waiting for a load response
    alu_res = 16'h0020; mem_rd = 1'b1; wb_sel = 2'd1; rf_we = 1'b1; waddr = 3'd2;
    @(posedge clk); #1;
    @(negedge clk);
    dmem_bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_bus.dmem_gnt = 1'b0;
    @(negedge clk);
    check("pre_rst_wait", {30'h0, dmem_bus.fsm_state}, 32'd2);
    @(posedge clk); #1;
    apply_reset();
    @(negedge clk);
    check("wrst_state", {30'h0, dmem_bus.fsm_state}, 32'd0);
    check("wrst_req",   {31'h0, dmem_bus.dmem_req}, 32'd0);
    check("wrst_out",   {11'h0, mem_err, rf_we_o, waddr_o, wb_data}, 32'd0);
    check("wrst_stall", {31'h0, stall}, 32'd0);
    dmem_bus.dmem_rvalid = 1'b1;
    dmem_bus.dmem_rdata  = 16'h5A5A;
    @(posedge clk); #1;
    dmem_bus.dmem_rvalid = 1'b0;
    run_op("late_rvalid", 0, 0, 16'h0, 16'h0, 2'd1, 1, 3'd7, 0, 1, 0, 0);

`ifdef MEM_TIMEOUT_EN
    // grant never given: watchdog forces completion
    run_op("timeout", 1, 0, 16'h0080, 16'h0, 2'd1, 1, 3'd2, 1000, 1, 0, 1);
    run_op("after_timeout", 0, 0, 16'h00AA, 16'h0, 2'd0, 1, 3'd1, 0, 1, 0, 0);
`endif

    // randomized mix of loads, stores and non-memory ops
    for (int n = 0; n < 40; n++) begin
      int   kind;
      logic r, w;
      kind = int'($urandom_range(0, 2));
      r = (kind == 1);
      w = (kind == 2);
      if (w && $urandom_range(0, 3) == 0) r = 1'b1;
      run_op($sformatf("rnd%0d", n), r, w, 16'($urandom), 16'($urandom),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
             int'($urandom_range(1, 3)), ($urandom_range(0, 3) == 0), 0);
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage datapath and sequencer that consumes the EX/MEM pipeline register outputs, performs load/store accesses over a request/grant/valid data-memory handshake, selects the write-back value and registers it into the MEM/WB boundary. Multi-cycle memory is absorbed by asserting `mem_stall`, which freezes the upstream pipeline registers.

## Interface
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles, 1..255; used only with `MEM_TIMEOUT_EN`.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `alu_res_in`, `store_data_in`, `pc2_in`, `imm_eff_in` in 16 each: EX/MEM values. `alu_res_in` is the memory address.
- `rf_we_in` in 1, `rf_waddr_in` in 3, `wb_sel_in` in 2: write-back control.
- `mem_rd_in`, `mem_wr_in` in 1 each: load/store; both high is treated as a store.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 16, `dmem_wdata` out 16: request channel.
- `dmem_gnt` in 1: request accepted.
- `dmem_rvalid` in 1, `dmem_rdata` in 16: read response.
- `mem_stall` out 1: combinational; high freezes the PC and all upstream pipeline registers.
- `wb_data_out` out 16, `rf_we_out` out 1, `rf_waddr_out` out 3: MEM/WB register.
- `mem_err_out` out 1: registered; timeout flag for this instruction.

## Operation
- `wb_sel` encoding: 0 = ALU, 1 = MEM, 2 = PC+2, 3 = IMM.
- FSM states and transitions:
  - IDLE: a memory op (`mem_rd_in | mem_wr_in`) moves to REQ. A non-memory op passes straight to the MEM/WB register.
  - REQ: drives `dmem_req`=1, `dmem_we`=`mem_wr_in`, `dmem_addr`=`alu_res_in`, `dmem_wdata`=`store_data_in`, held stable until `dmem_gnt`. On grant, a store goes to DONE and a load goes to WAIT.
  - WAIT: captures `dmem_rdata` into `load_q` on `dmem_rvalid`, then goes to DONE.
  - DONE: loads MEM/WB and returns to IDLE.
- `mem_stall` = memory op present and state != DONE.
- MEM/WB load:
  - `wb_data_out` = mux(`wb_sel_in`), with MEM selecting `load_q`.
  - `rf_we_out`/`rf_waddr_out` are copied from the inputs.
  - The register loads whenever `mem_stall`=0.
- `dmem_rvalid` is ignored outside WAIT, including a same-cycle rvalid in REQ.
- `dmem_req` is low in every state except REQ.
- Reset in any state, including mid-access: the FSM returns to IDLE next edge, and an outstanding response is dropped.

## Timing
- Reset values: all outputs 0, FSM IDLE, `load_q` 0.
- Non-memory op: 1-cycle latency, no stall.
- Store with immediate grant: IDLE, REQ, DONE. `mem_stall` is high for 2 cycles; MEM/WB updates at the end of the DONE cycle.
- Load with immediate grant and rvalid one cycle after grant: IDLE, REQ, WAIT, DONE. `mem_stall` is high for 3 cycles.
- Each cycle grant is withheld adds one REQ cycle; each cycle rvalid is late adds one WAIT cycle.
- Back-to-back memory ops: the second op enters REQ 2 cycles after the first leaves DONE (via IDLE). The FSM never goes DONE directly to REQ.

## Configuration
- Macro: `MEM_TIMEOUT_EN`.
- With the macro:
  - An 8-bit counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When the count reaches `TIMEOUT_CYCLES`, the FSM forces DONE. In that DONE cycle:
    - `dmem_req` drops.
    - `wb_data_out` = 16'hFFFF.
    - `rf_we_out` = 0.
    - `mem_err_out` = 1 for the instruction.
  - `mem_err_out` clears on the next MEM/WB load.
- Without the macro: no counter; `mem_err_out` is tied 0; the FSM waits indefinitely.

## Structure
- Shared package `mem_pkg`:
  - `wb_sel_e` enum (WB_ALU, WB_MEM, WB_PC2, WB_IMM).
  - `mem_state_e` enum (IDLE, REQ, WAIT, DONE).
  - Constant `TIMEOUT_W` = 8.
- One natural sub-module, `wb_mux`: combinational 4:1 write-back select. The FSM, counter and MEM/WB register stay in the top module.

## Test plan
- Reset during WAIT, then `rst` released: next cycle FSM IDLE, `dmem_req`=0, all outputs 0, and a late rvalid is ignored.
- ALU op, `alu_res_in`=16'h1234, `wb_sel`=0, `rf_we`=1, `waddr`=3: one cycle later `wb_data_out`=16'h1234, `rf_we_out`=1, `waddr`=3, `mem_stall` never high.
- Store, addr=16'h0040, data=16'hBEEF, gnt withheld 2 cycles: `dmem_req` high 3 cycles with stable addr/wdata, `dmem_we`=1, `mem_stall` high 4 cycles total, `rf_we_out`=0.
- Load, addr=16'h0010, rvalid 3 cycles after grant with rdata=16'hA5A5, plus a spurious rvalid in IDLE beforehand: `wb_data_out`=16'hA5A5, and the spurious rvalid has no effect.
- Load followed by ALU op 16'h0007: MEM/WB shows the load data, then 16'h0007 on the following cycle, with no lost or duplicated op.
- `MEM_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4 and gnt never given: DONE is reached after 4 REQ cycles, with `wb_data_out`=16'hFFFF, `rf_we_out`=0 and `mem_err_out`=1.
